cordic_phase_nco: RTL and testbench
===================================

CORDIC_PHASE_NCO -- requirements
Module: cordic_phase_nco

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, amplitude/x0/y0 width; PHASE_WIDTH, default 32, phase word width; ACC_WIDTH, default 25, accumulator width.
REQ-002 SHALL have port clk, input, 1, single clock, all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, begin a burst (sampled in IDLE only).
REQ-005 SHALL have port stop, input, 1, abort the current burst.
REQ-006 SHALL have port ftw, input, ACC_WIDTH, phase step per sample, degrees x 2^16; captured at start.
REQ-007 SHALL have port phase0, input, ACC_WIDTH, initial accumulator value; captured at start.
REQ-008 SHALL have port n_samples, input, 16, burst length; 0 means continuous; captured at start.
REQ-009 SHALL have port rate_div, input, 8, emit one sample every rate_div+1 cycles; captured at start.
REQ-010 SHALL have port amp, input, DATA_WIDTH, signed amplitude driven on x0; captured at start.
REQ-011 SHALL have outputs en (1), mode (1), x0 (DATA_WIDTH, signed), y0 (DATA_WIDTH, signed), phase (PHASE_WIDTH, {quadrant, value}), busy (1), done (1); all registered.

Function
REQ-012 SHALL use constants FULL = 23592960 (360 deg) and HALF = 11796480 (180 deg); acc is always held in [0, FULL).
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; busy is 1 in RUN only.
REQ-014 In IDLE, on start=1 and stop=0, SHALL capture inputs, load acc = phase0 (phase0 - FULL if phase0 >= FULL), clear the divider, and enter RUN.
REQ-015 In IDLE, start and stop both 1 SHALL be treated as stop (stay IDLE).
REQ-016 In RUN, SHALL emit sample k on the divider's terminal cycle: first sample on the first RUN cycle, then every rate_div+1 cycles.
REQ-017 Emission SHALL be registered: en=1 with phase derived from the current acc in the same clock edge; acc then advances by ftw, subtracting FULL when the sum >= FULL.
REQ-018 SHALL map theta = acc (acc < HALF) or acc - FULL (signed, range [-180, 180) deg): -90 <= theta < 90 gives phase = theta sign-extended; theta >= 90 gives {2'b01, (theta-90 deg)[29:0]}; theta < -90 gives {2'b10, (theta+90 deg)[29:0]}.
REQ-019 SHALL drive x0 = captured amp, y0 = 0, mode = 0 on every emitted sample; when en=0, phase/x0/y0 SHALL be 0.
REQ-020 After emitting the n_samples-th sample (n_samples != 0), SHALL enter DONE for one cycle with done=1, then IDLE.
REQ-021 stop in RUN SHALL return to IDLE on the next edge; no further en, no done pulse.
REQ-022 start in RUN or DONE SHALL be ignored; captured inputs SHALL not change mid-burst.
REQ-023 n_samples=0 SHALL run until stop; the sample counter SHALL not wrap to a terminal value.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, acc=0, all counters 0, and en, mode, x0, y0, phase, busy, done = 0; reset mid-burst SHALL abandon the burst with no done pulse.

Configuration
REQ-025 With CORDIC_NCO_DITHER_EN defined, SHALL add a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset, advancing per emitted sample) low 4 bits to acc before the REQ-018 mapping, with FULL wrap; acc itself is undithered.
REQ-026 Without CORDIC_NCO_DITHER_EN, SHALL contain no LFSR, and phase SHALL be the exact mapping of acc.

Structure
REQ-027 FULL, HALF, the 90-degree constant (5898240), the quadrant codes and the FSM state enum SHALL live in a shared package cordic_pkg.
REQ-028 The theta-to-{quadrant, value} mapping SHALL be a combinational sub-module cordic_quadrant_map.

Verification
REQ-029 ftw=5898240, phase0=0, n_samples=4, rate_div=0: SHALL give four consecutive en cycles with phase 0x00000000, 0x40000000, 0xBFA60000, 0xFFA60000, then done=1 for exactly one cycle.
REQ-030 ftw=FULL-1, phase0=0, n_samples=3: SHALL give phase 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE, covering the accumulator wrap.
REQ-031 rate_div=2, n_samples=3: en SHALL be high on RUN cycles 0, 3, 6 only; done follows the third sample.
REQ-032 n_samples=0, stop asserted on RUN cycle 10: SHALL give exactly 10 en pulses, busy falling on the next edge, and no done.
REQ-033 rst_n low at RUN cycle 5 of a 100-sample burst: all outputs SHALL be 0 immediately; start after release SHALL give a fresh burst from phase0.
REQ-034 phase0=FULL+100: first phase SHALL be 0x00000064; start and stop high together in IDLE SHALL give no en.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared angle constants, quadrant codes and FSM states for the CORDIC phase NCO.
// Angles are in degrees scaled by 2^16, so FULL is 360 * 65536.
package cordic_pkg;

    localparam int unsigned FULL    = 23592960;
    localparam int unsigned HALF    = 11796480;
    localparam int unsigned QUARTER = 5898240;

    localparam logic [1:0] QUAD_POS = 2'b01;
    localparam logic [1:0] QUAD_NEG = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_quadrant_map.sv
// Folds a signed angle in [-180, 180) degrees into the {quadrant, residual} word
// the CORDIC rotator expects, keeping the residual inside +/-90 degrees.
module cordic_quadrant_map
    import cordic_pkg::*;
#(
    parameter int ACC_WIDTH   = 25,
    parameter int PHASE_WIDTH = 32
) (
    input  logic signed [ACC_WIDTH-1:0] theta,
    output logic [PHASE_WIDTH-1:0]      phase
);

    localparam logic signed [PHASE_WIDTH-1:0] QTR = PHASE_WIDTH'(QUARTER);

    logic signed [PHASE_WIDTH-1:0] theta_ext;

    always_comb begin
        theta_ext = {{(PHASE_WIDTH-ACC_WIDTH){theta[ACC_WIDTH-1]}}, theta};
        phase     = theta_ext;
        if (theta_ext >= QTR) begin
            phase = {QUAD_POS, (PHASE_WIDTH-2)'(theta_ext - QTR)};
        end else if (theta_ext < -QTR) begin
            phase = {QUAD_NEG, (PHASE_WIDTH-2)'(theta_ext + QTR)};
        end
    end

endmodule

// File: rtl/cordic_phase_nco.sv
// Burst phase-accumulator NCO producing {quadrant, angle} samples for a CORDIC rotator.
// Define CORDIC_NCO_DITHER_EN to add 4-bit LFSR dither to the emitted phase.
module cordic_phase_nco
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int ACC_WIDTH   = 25
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [ACC_WIDTH-1:0]         ftw,
    input  logic [ACC_WIDTH-1:0]         phase0,
    input  logic [15:0]                  n_samples,
    input  logic [7:0]                   rate_div,
    input  logic signed [DATA_WIDTH-1:0] amp,
    output logic                         en,
    output logic                         mode,
    output logic signed [DATA_WIDTH-1:0] x0,
    output logic signed [DATA_WIDTH-1:0] y0,
    output logic [PHASE_WIDTH-1:0]       phase,
    output logic                         busy,
    output logic                         done
);

    localparam logic [ACC_WIDTH-1:0] FULL_A = ACC_WIDTH'(FULL);
    localparam logic [ACC_WIDTH-1:0] HALF_A = ACC_WIDTH'(HALF);
    localparam logic [ACC_WIDTH:0]   FULL_W = (ACC_WIDTH+1)'(FULL);

    state_t                       state, state_next;
    logic [ACC_WIDTH-1:0]         acc, ftw_q, acc_next, acc_eff, phase0_wrapped;
    logic [ACC_WIDTH:0]           acc_sum;
    logic [15:0]                  n_q, sample_cnt, sample_inc;
    logic [7:0]                   rate_q, div_cnt;
    logic signed [DATA_WIDTH-1:0] amp_q;
    logic                         launch, emit, last_sample;
    logic signed [ACC_WIDTH-1:0]  theta;
    logic [PHASE_WIDTH-1:0]       mapped;

    // Stop always wins: it blocks a launch in IDLE and suppresses emission in RUN.
    always_comb begin
        launch         = (state == IDLE) && start && !stop;
        emit           = (state == RUN) && !stop && (div_cnt == 8'd0);
        sample_inc     = sample_cnt + 16'd1;
        last_sample    = emit && (n_q != 16'd0) && (sample_inc == n_q);
        phase0_wrapped = (phase0 >= FULL_A) ? phase0 - FULL_A : phase0;
        acc_sum        = {1'b0, acc} + {1'b0, ftw_q};
        acc_next       = (acc_sum >= FULL_W) ? ACC_WIDTH'(acc_sum - FULL_W)
                                             : acc_sum[ACC_WIDTH-1:0];
    end

`ifdef CORDIC_NCO_DITHER_EN
    logic [15:0]        lfsr;
    logic [ACC_WIDTH:0] dither_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else if (emit) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        dither_sum = {1'b0, acc} + (ACC_WIDTH+1)'(lfsr[3:0]);
        acc_eff    = (dither_sum >= FULL_W) ? ACC_WIDTH'(dither_sum - FULL_W)
                                            : dither_sum[ACC_WIDTH-1:0];
    end
`else
    assign acc_eff = acc;
`endif

    assign theta = (acc_eff < HALF_A) ? acc_eff : acc_eff - FULL_A;

    cordic_quadrant_map #(
        .ACC_WIDTH  (ACC_WIDTH),
        .PHASE_WIDTH(PHASE_WIDTH)
    ) u_quadrant_map (
        .theta(theta),
        .phase(mapped)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (launch) state_next = RUN;
            RUN: begin
                if (stop)             state_next = IDLE;
                else if (last_sample) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Burst parameters are frozen at launch so mid-burst input changes have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            ftw_q      <= '0;
            n_q        <= '0;
            rate_q     <= '0;
            amp_q      <= '0;
            div_cnt    <= '0;
            sample_cnt <= '0;
        end else begin
            state <= state_next;
            if (launch) begin
                ftw_q      <= ftw;
                n_q        <= n_samples;
                rate_q     <= rate_div;
                amp_q      <= amp;
                acc        <= phase0_wrapped;
                div_cnt    <= '0;
                sample_cnt <= '0;
            end else if (emit) begin
                acc     <= acc_next;
                div_cnt <= rate_q;
                if (n_q != 16'd0) sample_cnt <= sample_inc;
            end else if (state == RUN) begin
                div_cnt <= div_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en    <= 1'b0;
            mode  <= 1'b0;
            x0    <= '0;
            y0    <= '0;
            phase <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            en   <= emit;
            mode <= 1'b0;
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            y0   <= '0;
            if (emit) begin
                phase <= mapped;
                x0    <= amp_q;
            end else begin
                phase <= '0;
                x0    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_phase_nco.sv
// Self-checking bench for cordic_phase_nco: directed vector table, reset and
// start/stop corner sequences, and randomized bursts against an arithmetic model.
module tb_cordic_phase_nco;

    localparam longint FULL_D = 23592960;
    localparam longint HALF_D = 11796480;
    localparam longint QTR_D  = 5898240;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic [24:0]        ftw;
    logic [24:0]        phase0;
    logic [15:0]        n_samples;
    logic [7:0]         rate_div;
    logic signed [15:0] amp;
    logic               en;
    logic               mode;
    logic signed [15:0] x0;
    logic signed [15:0] y0;
    logic [31:0]        phase;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [24:0]      f;
        logic [24:0]      p;
        logic [15:0]      n;
        logic [7:0]       r;
        logic [15:0]      a;
        int               stop_at;
        int               exp_count;
        int               n_exp;
        logic [3:0][31:0] ph;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] got_phase[$];
    int          n_en;
    int          model_count;

    cordic_phase_nco #(
        .DATA_WIDTH (16),
        .PHASE_WIDTH(32),
        .ACC_WIDTH  (25)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .ftw      (ftw),
        .phase0   (phase0),
        .n_samples(n_samples),
        .rate_div (rate_div),
        .amp      (amp),
        .en       (en),
        .mode     (mode),
        .x0       (x0),
        .y0       (y0),
        .phase    (phase),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Angle in scaled degrees -> expected phase word, straight from the angle rules.
    function automatic logic [31:0] model_phase(input longint a);
        longint theta;
        theta = (a < HALF_D) ? a : a - FULL_D;
        if (theta >= QTR_D)
            return 32'h4000_0000 | (32'(theta - QTR_D) & 32'h3FFF_FFFF);
        else if (theta < -QTR_D)
            return 32'h8000_0000 | (32'(theta + QTR_D) & 32'h3FFF_FFFF);
        else
            return 32'(theta);
    endfunction

    task automatic add_vec(input logic [24:0] f, input logic [24:0] p, input logic [15:0] n,
                           input logic [7:0] r, input logic [15:0] a, input int stop_at,
                           input int cnt, input int n_exp, input logic [31:0] p0,
                           input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3);
        vec_t v;
        v.f = f; v.p = p; v.n = n; v.r = r; v.a = a;
        v.stop_at = stop_at; v.exp_count = cnt; v.n_exp = n_exp;
        v.ph[0] = p0; v.ph[1] = p1; v.ph[2] = p2; v.ph[3] = p3;
        vt.push_back(v);
    endtask

    // Launches one burst and checks every output cycle by cycle; garbles the inputs
    // and toggles start while the burst runs, since neither may affect it.
    task automatic apply_stimulus(input logic [24:0] f, input logic [24:0] p,
                                  input logic [15:0] n, input logic [7:0] r,
                                  input logic [15:0] a, input int stop_at);
        int step, c_last, end_c, c, k;
        bit stopped, exp_en, exp_busy, exp_done;
        logic [31:0] exp_ph, exp_x;
        @(negedge clk);
        ftw = f; phase0 = p; n_samples = n; rate_div = r; amp = a;
        start = 1'b1; stop = 1'b0;
        step    = int'(r) + 1;
        c_last  = (n == 16'd0) ? -1 : (int'(n) - 1) * step;
        stopped = (stop_at >= 0) && ((n == 16'd0) || (stop_at <= c_last));
        end_c   = stopped ? stop_at : c_last;
        got_phase.delete();
        n_en = 0;
        model_count = 0;
        for (int j = 0; j <= end_c + 3; j++) begin
            @(negedge clk);
            exp_en = 1'b0;
            exp_ph = '0;
            exp_x  = '0;
            if (j >= 1) begin
                c = j - 1;
                if ((c % step == 0) && (stopped ? (c < stop_at) : (c <= c_last))) begin
                    k      = c / step;
                    exp_en = 1'b1;
                    exp_ph = model_phase((longint'(p) % FULL_D + longint'(k) * longint'(f)) % FULL_D);
                    exp_x  = {16'h0, a};
                    model_count++;
                end
            end
            exp_busy = (j <= end_c);
            exp_done = !stopped && (j == c_last + 1);
            check_output("en", {31'h0, en}, {31'h0, exp_en});
            check_output("busy", {31'h0, busy}, {31'h0, exp_busy});
            check_output("done", {31'h0, done}, {31'h0, exp_done});
            check_output("mode", {31'h0, mode}, 32'h0);
            check_output("phase", phase, exp_ph);
            check_output("x0", {16'h0, x0}, exp_x);
            check_output("y0", {16'h0, y0}, 32'h0);
            if (en) begin
                got_phase.push_back(phase);
                n_en++;
            end
            stop = stopped && (j == stop_at);
            if (j <= end_c) begin
                start     = 1'($urandom);
                ftw       = 25'($urandom);
                phase0    = 25'($urandom);
                n_samples = 16'($urandom);
                rate_div  = 8'($urandom);
                amp       = 16'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int          sa;
        logic [24:0] rf, rp;
        logic [15:0] rn;
        logic [7:0]  rr;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        ftw = '0; phase0 = '0; n_samples = '0; rate_div = '0; amp = '0;
        repeat (2) @(negedge clk);
        check_output("reset_en", {31'h0, en}, 32'h0);
        check_output("reset_busy", {31'h0, busy}, 32'h0);
        check_output("reset_done", {31'h0, done}, 32'h0);
        check_output("reset_phase", phase, 32'h0);
        check_output("reset_x0", {16'h0, x0}, 32'h0);
        rst_n = 1'b1;

        add_vec(25'd5898240, 25'd0, 16'd4, 8'd0, 16'h1234, -1, 4, 4,
                32'h0000_0000, 32'h4000_0000, 32'hBFA6_0000, 32'hFFA6_0000);
        add_vec(25'd23592959, 25'd0, 16'd3, 8'd0, 16'h8001, -1, 3, 3,
                32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0);
        add_vec(25'd1000, 25'd23593060, 16'd2, 8'd0, 16'h7FFF, -1, 2, 2,
                32'h0000_0064, 32'h0000_044C, 32'h0, 32'h0);
        add_vec(25'd1000, 25'd0, 16'd3, 8'd2, 16'h0001, -1, 3, 3,
                32'h0000_0000, 32'h0000_03E8, 32'h0000_07D0, 32'h0);
        add_vec(25'd100000, 25'd0, 16'd0, 8'd0, 16'hFFFF, 10, 10, 4,
                32'h0000_0000, 32'h0001_86A0, 32'h0003_0D40, 32'h0004_93E0);
        add_vec(25'd1, 25'd11796479, 16'd2, 8'd1, 16'h0055, -1, 2, 2,
                32'h4059_FFFF, 32'hBFA6_0000, 32'h0, 32'h0);
        add_vec(25'd1, 25'd17694719, 16'd2, 8'd0, 16'hAAAA, -1, 2, 2,
                32'hBFFF_FFFF, 32'hFFA6_0000, 32'h0, 32'h0);
        add_vec(25'd1, 25'd5898239, 16'd2, 8'd0, 16'h0F0F, -1, 2, 2,
                32'h0059_FFFF, 32'h4000_0000, 32'h0, 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            apply_stimulus(vt[i].f, vt[i].p, vt[i].n, vt[i].r, vt[i].a, vt[i].stop_at);
            check_output("tbl_count", 32'(n_en), 32'(vt[i].exp_count));
            for (int m = 0; m < vt[i].n_exp; m++) begin
                check_output("tbl_phase",
                             (m < got_phase.size()) ? got_phase[m] : 32'hDEAD_BEEF,
                             vt[i].ph[m]);
            end
        end

        // start and stop together in IDLE must not launch anything
        @(negedge clk);
        start = 1'b1; stop = 1'b1; ftw = 25'd1000; n_samples = 16'd2; rate_div = 8'd0;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int j = 0; j < 6; j++) begin
            check_output("startstop_en", {31'h0, en}, 32'h0);
            check_output("startstop_busy", {31'h0, busy}, 32'h0);
            @(negedge clk);
        end

        // reset in the middle of a long burst
        ftw = 25'd12345; phase0 = 25'd777; n_samples = 16'd100; rate_div = 8'd0;
        amp = 16'h0ABC; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_output("prereset_en", {31'h0, en}, 32'h1);
        check_output("prereset_phase", phase, model_phase(777 + 4 * 12345));
        rst_n = 1'b0;
        #1;
        check_output("midreset_en", {31'h0, en}, 32'h0);
        check_output("midreset_busy", {31'h0, busy}, 32'h0);
        check_output("midreset_phase", phase, 32'h0);
        check_output("midreset_x0", {16'h0, x0}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check_output("inreset_done", {31'h0, done}, 32'h0);
        end
        rst_n = 1'b1;
        apply_stimulus(25'd12345, 25'd777, 16'd3, 8'd0, 16'h0ABC, -1);
        check_output("postreset_count", 32'(n_en), 32'd3);
        check_output("postreset_first",
                     (got_phase.size() > 0) ? got_phase[0] : 32'hDEAD_BEEF, model_phase(777));

        for (int i = 0; i < 10; i++) begin
            rf = 25'($urandom_range(23592959, 0));
            rp = 25'($urandom);
            rr = 8'($urandom_range(3, 0));
            rn = 16'($urandom_range(6, 0));
            if (rn == 16'd0)
                sa = int'($urandom_range(20, 1));
            else if ($urandom_range(1, 0) == 1)
                sa = int'($urandom_range((int'(rn) - 1) * (int'(rr) + 1) + 1, 0));
            else
                sa = -1;
            apply_stimulus(rf, rp, rn, rr, 16'($urandom), sa);
            check_output("rand_count", 32'(n_en), 32'(model_count));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
